// File: rtl/ll_list_builder.sv
// Writer end of the linked-list path: chains incoming element pointers through a
// single next-table write port and hands the finished list head to the traverser.
module ll_list_builder #(
  parameter int n     = 16,
  parameter int Width = $clog2(n)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] in_ptr,
  input  logic             in_last,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic             wr_en,
  output logic [Width-1:0] wr_addr,
  output logic [Width-1:0] wr_data,
  output logic [Width-1:0] head,
  output logic [Width:0]   head_len,
  output logic             head_vld,
  input  logic             head_rdy,
  output logic             err_null
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUILD = 2'd1,
    S_TERM  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  localparam logic [Width:0] LenMax = (Width+1)'(n);
  localparam logic [Width:0] LenOne = (Width+1)'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [Width-1:0] r_head;
  logic [Width-1:0] r_tail;
  logic [Width:0]   r_len;
  logic [Width-1:0] r_head_out;
  logic [Width:0]   r_head_len;
  logic             r_wr_en;
  logic [Width-1:0] r_wr_addr;
  logic [Width-1:0] r_wr_data;
  logic             r_err_null;
  logic             w_xfer;
  logic             w_null;

  assign w_xfer = in_vld & in_rdy;
  assign w_null = (in_ptr == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer && !w_null && in_last) w_state_next = S_TERM;
               else if (w_xfer && !w_null)     w_state_next = S_BUILD;
      S_BUILD: if (w_xfer && in_last)          w_state_next = S_TERM;
      S_TERM:                                  w_state_next = S_EMIT;
      S_EMIT:  if (head_rdy)                   w_state_next = S_IDLE;
      default:                                 w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_rdy   = (r_state == S_IDLE) || (r_state == S_BUILD);
    head_vld = (r_state == S_EMIT);
  end

  // The head snapshot is taken in TERM so head/head_len survive the next list's build.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_len      <= '0;
      r_head_out <= '0;
      r_head_len <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err_null <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_err_null <= w_xfer & w_null;
      case (r_state)
        S_IDLE: begin
          if (w_xfer && !w_null) begin
            r_head <= in_ptr;
            r_tail <= in_ptr;
            r_len  <= LenOne;
          end
        end
        S_BUILD: begin
          if (w_xfer && !w_null) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_tail;
            r_wr_data <= in_ptr;
            r_tail    <= in_ptr;
            if (r_len < LenMax) r_len <= r_len + LenOne;
          end
        end
        S_TERM: begin
          r_wr_en    <= 1'b1;
          r_wr_addr  <= r_tail;
          r_wr_data  <= '0;
          r_head_out <= r_head;
          r_head_len <= r_len;
        end
        default: ;
      endcase
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign head     = r_head_out;
  assign head_len = r_head_len;
  assign err_null = r_err_null;

endmodule

// File: tb/tb_ll_list_builder.sv
// Scoreboard bench for ll_list_builder: a stream-level model predicts table writes and
// list heads; a monitor mirrors the table and walks every emitted list.
module tb_ll_list_builder;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_ptr;
  logic         in_last;
  logic         in_vld;
  logic         in_rdy;
  logic         wr_en;
  logic [W-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic [W-1:0] head;
  logic [W:0]   head_len;
  logic         head_vld;
  logic         head_rdy;
  logic         err_null;

  ll_list_builder #(.n(N), .Width(W)) dut (
    .clk(clk), .rst(rst), .in_ptr(in_ptr), .in_last(in_last), .in_vld(in_vld),
    .in_rdy(in_rdy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .head(head), .head_len(head_len), .head_vld(head_vld), .head_rdy(head_rdy),
    .err_null(err_null)
  );

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int seen_err = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  int cur[$];
  int exp_wa[$];
  int exp_wd[$];
  int exp_head[$];
  int exp_len[$];
  int exp_trav[$];
  int mem [N];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Stream-level reference: a list is the non-null pointers seen up to a last flag.
  task automatic finalize();
    exp_wa.push_back(cur[cur.size()-1]);
    exp_wd.push_back(0);
    exp_head.push_back(cur[0]);
    exp_len.push_back(cur.size() < N ? cur.size() : N);
    foreach (cur[i]) exp_trav.push_back(cur[i]);
    cur.delete();
  endtask

  task automatic model_accept(input int p, input bit l);
    if (p == 0) begin
      exp_err++;
      if (l && cur.size() > 0) finalize();
    end else begin
      if (cur.size() > 0) begin
        exp_wa.push_back(cur[cur.size()-1]);
        exp_wd.push_back(p);
      end
      cur.push_back(p);
      if (l) finalize();
    end
  endtask

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send(input int p, input bit l);
    int cnt;
    cnt = 0;
    in_ptr  = W'(p);
    in_last = l;
    in_vld  = 1'b1;
    while (!in_rdy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_rdy) begin
      chk("send_timeout", 0, 1);
      in_vld = 1'b0;
      return;
    end
    model_accept(p, l);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  initial begin
    head_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       head_rdy = 1'b1;
        1:       head_rdy = 1'($urandom_range(1, 0));
        default: head_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: table writes, error pulses, head transfers, stall stability.
  initial begin
    bit stall_prev;
    int prev_head, prev_len, node, e;
    stall_prev = 1'b0;
    prev_head = 0;
    prev_len = 0;
    for (int i = 0; i < N; i++) mem[i] = 0;
    forever begin
      @(negedge clk);
      if (err_null) seen_err++;
      if (wr_en) begin
        if (exp_wa.size() == 0) begin
          chk("unexpected_write", int'(wr_addr), -1);
        end else begin
          chk("wr_addr", int'(wr_addr), exp_wa.pop_front());
          chk("wr_data", int'(wr_data), exp_wd.pop_front());
        end
        mem[wr_addr] = int'(wr_data);
      end
      if (head_vld) chk("in_rdy_during_emit", int'(in_rdy), 0);
      if (stall_prev && head_vld) begin
        chk("stall_head", int'(head), prev_head);
        chk("stall_len", int'(head_len), prev_len);
      end
      if (stall_prev) chk("stall_vld_held", int'(head_vld), 1);
      if (head_vld && head_rdy) begin
        $display("head transfer head=%0d len=%0d", head, head_len);
        if (exp_head.size() == 0) begin
          chk("unexpected_head", int'(head), -1);
        end else begin
          chk("head", int'(head), exp_head.pop_front());
          chk("head_len", int'(head_len), exp_len.pop_front());
          node = int'(head);
          for (int i = 0; i < int'(head_len); i++) begin
            e = (exp_trav.size() > 0) ? exp_trav.pop_front() : -1;
            chk("trav_node", node, e);
            node = mem[node];
          end
          chk("trav_end", node, 0);
        end
      end
      stall_prev = head_vld && !head_rdy;
      prev_head  = int'(head);
      prev_len   = int'(head_len);
    end
  end

  initial begin
    int cnt, perm[15], tmp, j, len;
    rst = 1'b1;
    in_ptr = '0;
    in_last = 1'b0;
    in_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_head", int'(head), 0);
    chk("rst_head_len", int'(head_len), 0);
    chk("rst_head_vld", int'(head_vld), 0);
    chk("rst_err_null", int'(err_null), 0);
    chk("rst_in_rdy", int'(in_rdy), 1);
    rst = 1'b0;
    @(negedge clk);

    // 7,15,8: in_rdy low for exactly TERM + one EMIT cycle
    send(7, 0); send(15, 0); send(8, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (!in_rdy) cnt++;
      @(negedge clk);
    end
    chk("rdy_low_cycles", cnt, 2);

    // single element: terminator write coincides with first EMIT cycle
    send(6, 1);
    @(negedge clk);
    chk("single_wr_en_emit", int'(wr_en), 1);
    chk("single_vld_emit", int'(head_vld), 1);
    repeat (3) @(negedge clk);

    // long list with downstream stalled for 5 cycles
    rdy_mode = 2;
    send(9, 0); send(14, 0); send(11, 0); send(13, 0); send(12, 1);
    cnt = 0;
    while (!head_vld && cnt < 20) begin @(negedge clk); cnt++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall5_vld", int'(head_vld), 1);
      chk("stall5_head", int'(head), 9);
      chk("stall5_len", int'(head_len), 5);
      chk("stall5_in_rdy", int'(in_rdy), 0);
      @(negedge clk);
    end
    rdy_mode = 0;
    send(2, 0); send(4, 1);
    repeat (4) @(negedge clk);

    // nulls: mid-list drop, and a lone null-last in IDLE
    send(1, 0); send(0, 0); send(5, 1);
    repeat (4) @(negedge clk);
    send(0, 1);
    repeat (4) @(negedge clk);
    chk("idle_null_no_head", int'(head_vld), 0);

    // reset mid-build abandons the list
    send(3, 0); send(10, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_wr_addr", int'(wr_addr), 0);
    chk("mid_rst_wr_data", int'(wr_data), 0);
    chk("mid_rst_head", int'(head), 0);
    chk("mid_rst_head_len", int'(head_len), 0);
    chk("mid_rst_head_vld", int'(head_vld), 0);
    chk("mid_rst_err_null", int'(err_null), 0);
    chk("mid_rst_in_rdy", int'(in_rdy), 1);
    cur.delete();
    rst = 1'b0;
    send(1, 1);
    repeat (4) @(negedge clk);

    // random lists of distinct pointers with sprinkled nulls
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 15; i++) perm[i] = i + 1;
      for (int i = 14; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      len = int'($urandom_range(7, 1));
      if ($urandom_range(9, 0) == 0) begin
        for (int k = 0; k < len; k++) send(perm[k], 0);
        send(0, 1);
      end else begin
        for (int k = 0; k < len; k++) begin
          if ($urandom_range(7, 0) == 0) send(0, 0);
          send(perm[k], k == len - 1);
          repeat ($urandom_range(1, 0)) @(negedge clk);
        end
      end
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    rdy_mode = 0;
    cnt = 0;
    while ((exp_head.size() > 0 || exp_wa.size() > 0) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    repeat (3) @(negedge clk);
    chk("drain_writes", exp_wa.size(), 0);
    chk("drain_heads", exp_head.size(), 0);
    chk("drain_trav", exp_trav.size(), 0);
    chk("err_null_count", seen_err, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
